// File: rtl/diffuse_rand_gen_if.sv
// Host/shader-facing bundle for diffuse_rand_gen: burst control in,
// Q3.13 random pairs and status out.
interface diffuse_rand_gen_if;
  logic               seed_vld;
  logic        [31:0] seed;
  logic               start;
  logic        [15:0] count;
  logic               stall;
  logic               busy;
  logic               done;
  logic               op_vld;
  logic signed [15:0] r1;
  logic signed [15:0] r2;
  logic        [15:0] rejects;

  modport master (
    output seed_vld, seed, start, count, stall,
    input  busy, done, op_vld, r1, r2, rejects
  );

  modport slave (
    input  seed_vld, seed, start, count, stall,
    output busy, done, op_vld, r1, r2, rejects
  );
endinterface

// File: rtl/diffuse_rand_gen.sv
// xorshift32-based generator of Q3.13 pairs strictly inside (-1.0, 1.0),
// emitted in host-requested bursts for the diffuse-bounce shader.
module diffuse_rand_gen #(
  parameter logic [31:0] DEFAULT_SEED = 32'h2545F491
) (
  input  logic               clk,
  input  logic               rst_n,
  diffuse_rand_gen_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic signed [15:0] NEG_ONE = 16'shE000;

  state_t             state_q, state_d;
  logic        [31:0] x_q, x_d;
  logic        [15:0] remaining_q, remaining_d;
  logic        [15:0] rejects_q, rejects_d;
  logic               op_vld_q, op_vld_d;
  logic signed [15:0] r1_q, r1_d;
  logic signed [15:0] r2_q, r2_d;

  logic        [31:0] x_adv;
  logic signed [15:0] cand_r1, cand_r2;
  logic               draw, reject;

  function automatic logic [31:0] xs_next(input logic [31:0] x);
    logic [31:0] t;
    t = x ^ (x << 13);
    t = t ^ (t >> 17);
    t = t ^ (t << 5);
    return t;
  endfunction

  // 14-bit two's-complement field widened to Q3.13 by sign extension.
  function automatic logic signed [15:0] to_q313(input logic [13:0] f);
    return $signed({f[13], f[13], f});
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    x_adv   = xs_next(x_q);
    cand_r1 = to_q313(x_adv[13:0]);
    cand_r2 = to_q313(x_adv[29:16]);
    reject  = (cand_r1 == NEG_ONE) || (cand_r2 == NEG_ONE);
    draw    = (state_q == RUN) && !bus.stall && (remaining_q != 16'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      x_q         <= DEFAULT_SEED;
      remaining_q <= 16'd0;
      rejects_q   <= 16'd0;
      op_vld_q    <= 1'b0;
      r1_q        <= 16'sd0;
      r2_q        <= 16'sd0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      remaining_q <= remaining_d;
      rejects_q   <= rejects_d;
      op_vld_q    <= op_vld_d;
      r1_q        <= r1_d;
      r2_q        <= r2_d;
    end
  end

  // RUN lingers one cycle after the last accepted pair so done trails op_vld.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (remaining_q == 16'd0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    x_d         = x_q;
    remaining_d = remaining_q;
    rejects_d   = rejects_q;
    op_vld_d    = 1'b0;
    r1_d        = r1_q;
    r2_d        = r2_q;
    if (state_q == IDLE) begin
      if (bus.seed_vld) x_d = (bus.seed == 32'd0) ? DEFAULT_SEED : bus.seed;
      if (bus.start) begin
        remaining_d = bus.count;
        rejects_d   = 16'd0;
      end
    end
    if (draw) begin
      x_d = x_adv;
      if (reject) begin
        rejects_d = sat_inc(rejects_q);
      end else begin
        op_vld_d    = 1'b1;
        r1_d        = cand_r1;
        r2_d        = cand_r2;
        remaining_d = remaining_q - 16'd1;
      end
    end
  end

  always_comb begin
    bus.busy    = (state_q == RUN);
    bus.done    = (state_q == DONE);
    bus.op_vld  = op_vld_q;
    bus.r1      = r1_q;
    bus.r2      = r2_q;
    bus.rejects = rejects_q;
  end

endmodule

// File: tb/tb_diffuse_rand_gen.sv
// Scoreboard bench for diffuse_rand_gen: a cycle-timeline model predicts
// op_vld/done/busy per cycle and queues the expected pairs for the monitor.
module tb_diffuse_rand_gen;

  localparam logic [31:0] DEF = 32'h2545F491;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  diffuse_rand_gen_if bus ();

  diffuse_rand_gen dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0] r1;
    logic [15:0] r2;
  } pair_t;

  pair_t       sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] mx       = DEF;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] adv(input logic [31:0] x);
    logic [31:0] t;
    t = x ^ (x << 13);
    t = t ^ (t >> 17);
    t = t ^ (t << 5);
    return t;
  endfunction

  // Value of a 14-bit signed field, in LSBs of 2^-13.
  function automatic int field_val(input logic [13:0] f);
    int v;
    v = int'(f);
    if (v >= 8192) v = v - 16384;
    return v;
  endfunction

  // Monitor: every op_vld must match the oldest predicted pair.
  always @(negedge clk) begin
    pair_t e;
    if (rst_n && bus.op_vld) begin
      chk("r1_not_neg1", {31'd0, bus.r1 == 16'hE000}, 32'd0);
      chk("r2_not_neg1", {31'd0, bus.r2 == 16'hE000}, 32'd0);
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_op_vld: got r1=%0h r2=%0h with no pair expected", bus.r1, bus.r2);
      end else begin
        e = sb.pop_front();
        chk("r1", {16'd0, bus.r1}, {16'd0, e.r1});
        chk("r2", {16'd0, bus.r2}, {16'd0, e.r2});
      end
    end
  end

  function automatic bit in_rng(input int k, input int lo, input int hi);
    return (k >= lo) && (k <= hi);
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic burst(input bit load, input logic [31:0] sd, input int n,
                       input int st_lo, input int st_hi, input bit noise);
    bit exp_op[$];
    int acc, rej, k, done_idx, v1, v2;
    acc = 0;
    rej = 0;
    k   = 0;
    if (load) mx = (sd == 32'd0) ? DEF : sd;
    exp_op.push_back(1'b0);
    while (acc < n) begin
      k++;
      if (in_rng(k, st_lo, st_hi)) begin
        exp_op.push_back(1'b0);
      end else begin
        mx = adv(mx);
        v1 = field_val(mx[13:0]);
        v2 = field_val(mx[29:16]);
        if (v1 == -8192 || v2 == -8192) begin
          rej++;
          exp_op.push_back(1'b0);
        end else begin
          sb.push_back('{r1: 16'(v1), r2: 16'(v2)});
          acc++;
          exp_op.push_back(1'b1);
        end
      end
    end
    done_idx = k + 1;

    bus.seed_vld = load;
    bus.seed     = sd;
    bus.start    = 1'b1;
    bus.count    = n[15:0];
    bus.stall    = 1'b0;
    @(negedge clk);
    bus.seed_vld = 1'b0;
    bus.start    = 1'b0;
    chk("busy_after_start", {31'd0, bus.busy}, 32'd1);
    chk("op_vld_after_start", {31'd0, bus.op_vld}, 32'd0);
    bus.stall = in_rng(1, st_lo, st_hi);
    for (int c = 1; c <= done_idx; c++) begin
      @(negedge clk);
      if (noise && c == 2) begin
        bus.seed_vld = 1'b1;
        bus.seed     = $urandom;
        bus.start    = 1'b1;
        bus.count    = 16'd5;
      end else begin
        bus.seed_vld = 1'b0;
        bus.start    = 1'b0;
      end
      chk("op_vld_timeline", {31'd0, bus.op_vld}, {31'd0, (c < done_idx) ? exp_op[c] : 1'b0});
      chk("done_timeline", {31'd0, bus.done}, {31'd0, c == done_idx});
      chk("busy_timeline", {31'd0, bus.busy}, {31'd0, c < done_idx});
      bus.stall = in_rng(c + 1, st_lo, st_hi);
    end
    chk("rejects", {16'd0, bus.rejects}, rej);
    chk("sb_drained", sb.size(), 32'd0);
    bus.stall = 1'b0;
    @(negedge clk);
    chk("done_one_cycle", {31'd0, bus.done}, 32'd0);
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, bus.done}, 32'd0);
    chk({tag, "_op_vld"}, {31'd0, bus.op_vld}, 32'd0);
    chk({tag, "_r1"}, {16'd0, bus.r1}, 32'd0);
    chk({tag, "_r2"}, {16'd0, bus.r2}, 32'd0);
    chk({tag, "_rejects"}, {16'd0, bus.rejects}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] t, rseed;
    int ops, lo, n;
    bus.seed_vld = 1'b0;
    bus.seed     = 32'd0;
    bus.start    = 1'b0;
    bus.count    = 16'd0;
    bus.stall    = 1'b0;
    repeat (3) @(negedge clk);
    chk_cleared("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Seed 1, one pair: the known first xorshift output.
    burst(1'b1, 32'd1, 1, 0, -1, 1'b0);
    chk("seed1_r1", {16'd0, bus.r1}, 32'h0000E021);
    chk("seed1_r2", {16'd0, bus.r2}, 32'h00000004);

    // Zero seed maps to the default seed; then the default seed explicitly.
    burst(1'b1, 32'd0, 3, 0, -1, 1'b0);
    burst(1'b1, DEF, 3, 0, -1, 1'b0);

    // Seed whose first draw lands on r1 == -1.0.
    rseed = 32'd1;
    for (int s = 1; s < 4194304; s++) begin
      t = adv(s);
      if (t[13:0] == 14'h2000) begin
        rseed = s;
        break;
      end
    end
    burst(1'b1, rseed, 3, 0, -1, 1'b0);
    chk("reject_seen", {31'd0, bus.rejects != 16'd0}, 32'd1);

    // Stall across draws 3..5 of an 8-pair burst.
    burst(1'b1, $urandom, 8, 3, 5, 1'b0);

    // start/seed_vld pulsed mid-burst must be ignored.
    burst(1'b1, $urandom, 6, 0, -1, 1'b1);

    // Empty burst, continuing the current state.
    burst(1'b0, 32'd0, 0, 0, -1, 1'b0);

    for (int i = 0; i < 6; i++) begin
      n  = $urandom_range(12, 1);
      lo = $urandom_range(n, 1);
      burst($urandom_range(1, 0), $urandom, n, lo, lo + $urandom_range(3, 0), 1'b0);
    end

    // Reset after two of ten pairs.
    mx = $urandom;
    bus.seed_vld = 1'b1;
    bus.seed     = mx;
    bus.start    = 1'b1;
    bus.count    = 16'd10;
    if (mx == 32'd0) mx = DEF;
    for (int i = 0; i < 12; i++) begin
      mx = adv(mx);
      if (field_val(mx[13:0]) != -8192 && field_val(mx[29:16]) != -8192)
        sb.push_back('{r1: 16'(field_val(mx[13:0])), r2: 16'(field_val(mx[29:16]))});
    end
    @(negedge clk);
    bus.seed_vld = 1'b0;
    bus.start    = 1'b0;
    ops = 0;
    for (int c = 0; c < 30 && ops < 2; c++) begin
      @(negedge clk);
      if (bus.op_vld) ops++;
    end
    chk("two_ops_before_reset", ops, 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk_cleared("async_reset");
    sb.delete();
    mx = DEF;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("no_done_in_reset", {31'd0, bus.done}, 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("no_done_after_reset", {31'd0, bus.done}, 32'd0);

    burst(1'b1, 32'd1, 1, 0, -1, 1'b0);
    chk("restart_r1", {16'd0, bus.r1}, 32'h0000E021);
    chk("restart_r2", {16'd0, bus.r2}, 32'h00000004);
    chk("restart_rejects", {16'd0, bus.rejects}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/diffuse_rand_gen.md
# diffuse_rand_gen

Generates the pseudo-random Q3.13 pairs (r1, r2) consumed by the diffuse-bounce direction stage, one pair per cycle, from a seeded xorshift32 sequence. Sits directly upstream of the diffuse shader: `op_vld`/`r1`/`r2` connect straight to its inputs. A host-side `start` requests a burst of N pairs. The block guarantees every emitted value lies in the open interval (-1.0, 1.0).

## Interface
- `DEFAULT_SEED`, 32'h2545F491, state after reset and replacement for a zero seed.
- `clk`  in  1  clock, all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `seed_vld`  in  1  load `seed`; honoured only in IDLE.
- `seed`  in  32  new xorshift state; 0 is replaced by `DEFAULT_SEED`.
- `start`  in  1  begin a burst; honoured only in IDLE.
- `count`  in  16  number of pairs to emit, sampled with `start`.
- `stall`  in  1  freeze generation this cycle.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse at end of burst.
- `op_vld`  out  1  r1/r2 valid this cycle.
- `r1`  out  16  Q3.13 value in (-1.0, 1.0).
- `r2`  out  16  Q3.13 value in (-1.0, 1.0).
- `rejects`  out  16  saturating count of rejected draws since the last `start`.

## Operation
- State `x` (32 b). Advance: x ^= x<<13; x ^= x>>17; x ^= x<<5.
- Candidate pair is taken from the advanced value x': r1 = {x'[13],x'[13],x'[13:0]}, r2 = {x'[29],x'[29],x'[29:16]}. Range is [-8192, 8191], i.e. [-1.0, 0.99988].
- Reject: if r1 == 16'hE000 or r2 == 16'hE000 (-1.0):
  - x still advances;
  - no op_vld;
  - remaining count unchanged;
  - `rejects` increments and saturates at 16'hFFFF.
- FSM IDLE / RUN / DONE:
  - IDLE: `seed_vld` loads x (seed==0 loads DEFAULT_SEED). `start` latches `remaining`=`count` and clears `rejects`, then goes to RUN. If `start` and `seed_vld` are both high, the seed loads and the burst begins from that seed.
  - RUN: with !stall, each cycle advances x and registers the candidate. If it is accepted, op_vld=1 next cycle and `remaining` decrements. When the accepted pair makes remaining 0, go to DONE. If `count`==0 at start, RUN goes to DONE on the first cycle with no draw.
  - DONE: `done`=1 for exactly one cycle, then IDLE.
- `start` and `seed_vld` are ignored outside IDLE.
- `stall` in RUN:
  - x, `remaining` and `rejects` hold;
  - op_vld=0 on the following cycle;
  - r1/r2 keep their last values.
- r1/r2 change only on accepted draws.

## Timing
- Reset (async assert, sync-released by the system): FSM=IDLE, x=DEFAULT_SEED, remaining=0, busy=0, done=0, op_vld=0, r1=0, r2=0, rejects=0.
- `start` sampled at edge E0 → `busy`=1 after E0. The first draw is evaluated in the cycle after E0, so the first op_vld is visible after E1 (1 cycle latency from the RUN entry edge).
- Steady state with no stalls and no rejects: op_vld is high on N consecutive cycles.
- `done` is high the cycle after the last op_vld; `busy` falls in the same edge that raises `done`. A new `start` is accepted on the cycle after `done`.
- No backpressure from downstream: op_vld is a pulse and the consumer must accept it. `stall` is the only throttle, and it takes effect on the op_vld one cycle later.
- Reset mid-burst aborts immediately: all outputs return to reset values and no `done` is emitted.

## Test plan
- Reset, seed_vld with seed=1, start with count=1 → one op_vld with x'=32'h00042021, r1=16'hE021, r2=16'h0004; done one cycle later; rejects=0.
- Seed=0 then start with count=3 → sequence identical to seed=DEFAULT_SEED. A golden model matches 3 pairs on consecutive cycles, and busy drops as done rises.
- Force a reject by loading a seed whose advanced value has x'[13:0]=14'h2000 (solve in the model) → no op_vld that cycle, rejects=1, and the burst still delivers exactly `count` pairs.
- count=8 with stall high on cycles 3–5 → exactly 8 op_vld; a 3-cycle gap appears 1 cycle later than the stall; the values match the unstalled golden stream.
- start and seed_vld asserted during RUN → no effect on the stream or count. count=0 → done after 2 cycles with no op_vld.
- rst_n low mid-burst (after 2 of 10 pairs) → outputs cleared asynchronously, no done. A restart with seed 1 reproduces the first test's output.
